disp_chan_mux: RTL and testbench

Parametrised N-channel display selector that sits between the sensor/ADC data paths and the 4-digit seven-segment driver. It snapshots each channel's BCD word on a valid strobe and selects one channel for display from a debounced button. It also generates per-channel decimal-point and leading-zero-blanking controls. Optionally, a long press toggles an auto-rotate mode that cycles channels on a dwell timer.

---
 rtl/disp_pkg.sv | 9 +
 rtl/disp_press.sv | 39 +++
 rtl/disp_chan_mux.sv | 96 +++++++++
 tb/tb_disp_chan_mux.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and helpers for the display channel mux
package disp_pkg;
  localparam int DIGIT_W = 4;
  localparam int DWELL_DEF = 50_000_000;
  localparam int LONG_PRESS_DEF = 50_000_000;
  function automatic int chan_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/disp_press.sv
// disp_press: button rise detector and short/long press classifier.
// Long-press timing exists only when DISP_AUTOROTATE_EN is defined.
module disp_press import disp_pkg::*; #(
  parameter int LONG_PRESS = LONG_PRESS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise,
  output logic short_press,
  output logic long_press
);
  logic btn_q, armed;
  // armed stays low until btn is seen released, so a press held through reset is ignored
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      btn_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      btn_q <= btn;
      armed <= armed | ~btn;
    end
  assign rise = btn & ~btn_q & armed;
`ifdef DISP_AUTOROTATE_EN
  localparam int PW = $clog2(LONG_PRESS + 1);
  logic [PW-1:0] cnt;
  logic sat;
  assign sat = cnt == PW'(LONG_PRESS);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (btn & armed) ? (sat ? cnt : cnt + 1'b1) : '0;
  assign short_press = ~btn & btn_q & armed & ~sat;
  assign long_press = btn & armed & (cnt == PW'(LONG_PRESS - 1));
`else
  localparam int unused_long_press = LONG_PRESS;
  assign short_press = 1'b0;
  assign long_press = 1'b0;
`endif
endmodule

// File: rtl/disp_chan_mux.sv
// disp_chan_mux: per-channel BCD snapshot bank and display selector with dp/blanking control.
// Define DISP_AUTOROTATE_EN to add long-press toggled auto-rotate on a dwell timer.
module disp_chan_mux import disp_pkg::*; #(
  parameter int NCH = 4,
  parameter int DIGITS = 4,
  parameter logic [NCH*DIGITS-1:0] DP_MASK = '0,
  parameter bit LZB = 1'b1,
  parameter int DWELL = DWELL_DEF,
  parameter int LONG_PRESS = LONG_PRESS_DEF,
  localparam int DW = DIGIT_W * DIGITS,
  localparam int CW = chan_w(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic              hold,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH-1:0]    valid_in,
  output logic [DW-1:0]     dataout,
  output logic [DIGITS-1:0] dp,
  output logic [DIGITS-1:0] turn_off,
  output logic [CW-1:0]     chan,
  output logic              chan_stb,
  output logic              auto
);
  logic [DW-1:0] snap [NCH];
  logic seen [NCH];
  logic [DIGITS-1:0] dp_tab [NCH];
  logic rise, short_press, long_press, adv;
  disp_press #(.LONG_PRESS(LONG_PRESS)) u_press (
    .clk(clk), .rst(rst), .btn(btn),
    .rise(rise), .short_press(short_press), .long_press(long_press)
  );
  for (genvar c = 0; c < NCH; c++) begin : g_snap
    assign dp_tab[c] = DP_MASK[c*DIGITS +: DIGITS];
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        snap[c] <= '0;
        seen[c] <= 1'b0;
      end else if (valid_in[c]) begin
        snap[c] <= data_in[c*DW +: DW];
        seen[c] <= 1'b1;
      end
  end
`ifdef DISP_AUTOROTATE_EN
  localparam int TW = $clog2(DWELL);
  logic [TW-1:0] dwell;
  logic expire, unused_rise;
  assign unused_rise = rise;
  assign expire = auto & (dwell == TW'(DWELL - 1));
  assign adv = short_press | expire;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dwell <= '0;
      auto <= 1'b0;
    end else begin
      dwell <= (~auto | short_press | long_press | expire) ? '0 : dwell + 1'b1;
      auto <= auto ^ long_press;
    end
`else
  localparam int unused_dwell = DWELL;
  logic unused_press;
  assign unused_press = short_press | long_press;
  assign adv = rise;
  assign auto = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      chan <= '0;
      chan_stb <= 1'b0;
    end else begin
      chan_stb <= adv;
      if (adv) chan <= (chan == CW'(NCH - 1)) ? '0 : chan + 1'b1;
    end
  logic [DW-1:0] cur;
  logic [DIGITS-1:0] dp_c, lz;
  logic [DIGITS-1:1] zero;
  assign cur = snap[chan];
  assign dp_c = dp_tab[chan];
  assign lz[0] = 1'b0;
  // a digit is blankable only if it and every digit above it is zero without a dp
  for (genvar g = 1; g < DIGITS; g++) begin : g_lz
    assign zero[g] = (cur[g*DIGIT_W +: DIGIT_W] == '0) & ~dp_c[g];
    assign lz[g] = LZB & (&zero[DIGITS-1:g]);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dataout <= '0;
      dp <= '0;
      turn_off <= '1;
    end else if (!hold) begin
      dataout <= cur;
      dp <= dp_c;
      turn_off <= seen[chan] ? lz : '1;
    end
endmodule

// File: tb/tb_disp_chan_mux.sv
// tb_disp_chan_mux: directed scenarios plus randomized run against a behavioural model.
module tb_disp_chan_mux;
  localparam int NCH = 4, DIGITS = 4, DW = 16, DWELL = 8, LP = 4;
  localparam logic [15:0] DP_MASK = 16'h4020;
  logic clk = 1'b0, rst = 1'b0, btn = 1'b0, hold = 1'b0;
  logic [NCH*DW-1:0] data_in = '0;
  logic [NCH-1:0] valid_in = '0;
  logic [DW-1:0] dataout;
  logic [3:0] dp, turn_off;
  logic [1:0] chan;
  logic chan_stb, auto;
  int vectors = 0, errors = 0;

  disp_chan_mux #(.NCH(NCH), .DIGITS(DIGITS), .DP_MASK(DP_MASK), .LZB(1'b1),
                  .DWELL(DWELL), .LONG_PRESS(LP)) dut (
    .clk(clk), .rst(rst), .btn(btn), .hold(hold), .data_in(data_in), .valid_in(valid_in),
    .dataout(dataout), .dp(dp), .turn_off(turn_off), .chan(chan), .chan_stb(chan_stb), .auto(auto)
  );

  always #5 clk = ~clk;

  logic [15:0] m_snap [NCH];
  bit m_seen [NCH];
  int m_chan, m_held, m_dwell;
  bit m_prev, m_armed, m_auto, e_stb;
  logic [15:0] e_data;
  logic [3:0] e_dp, e_to;

  function automatic logic [3:0] dp_of(input int ch);
    logic [15:0] m;
    m = DP_MASK;
    return m[ch*4 +: 4];
  endfunction

  // count significant digits from the top; everything above them is blanked
  function automatic logic [3:0] blank_of(input int ch);
    int n;
    logic [3:0] d;
    if (!m_seen[ch]) return 4'hF;
    n = DIGITS;
    d = dp_of(ch);
    while (n > 1 && ((m_snap[ch] >> (4 * (n - 1))) & 16'hF) == 0 && !d[n-1]) n--;
    return 4'(16 - (1 << n));
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit adv;
`ifdef DISP_AUTOROTATE_EN
    bit rel, tog, expd;
`endif
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin m_snap[c] = '0; m_seen[c] = 0; end
      m_chan = 0; m_held = 0; m_dwell = 0;
      m_prev = 0; m_armed = 0; m_auto = 0; e_stb = 0;
      e_data = '0; e_dp = '0; e_to = 4'hF;
    end else begin
      if (!hold) begin
        e_data = m_snap[m_chan];
        e_dp = dp_of(m_chan);
        e_to = blank_of(m_chan);
      end
`ifdef DISP_AUTOROTATE_EN
      rel = !btn && m_prev && m_armed && m_held < LP;
      tog = btn && m_armed && m_held == LP - 1;
      m_held = (btn && m_armed) ? ((m_held < LP) ? m_held + 1 : LP) : 0;
      expd = m_auto && m_dwell == DWELL - 1;
      adv = rel || expd;
      m_dwell = (!m_auto || rel || tog || expd) ? 0 : m_dwell + 1;
      if (tog) m_auto = !m_auto;
`else
      adv = btn && !m_prev && m_armed;
`endif
      m_armed = m_armed || !btn;
      m_prev = btn;
      for (int c = 0; c < NCH; c++)
        if (valid_in[c]) begin m_snap[c] = data_in[c*DW +: DW]; m_seen[c] = 1; end
      e_stb = adv;
      if (adv) m_chan = (m_chan + 1) % NCH;
    end
  end

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    for (int d = 0; d < 4; d++) w[d*4 +: 4] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(9));
    return w;
  endfunction

  task automatic press(input int len, output int stb);
    stb = 0;
    btn = 1'b1;
    repeat (len) begin @(negedge clk); stb += int'(chan_stb); end
    btn = 1'b0;
    repeat (4) begin @(negedge clk); stb += int'(chan_stb); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({chan, chan_stb, auto} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got chan=%0d stb=%b auto=%b want 0", chan, chan_stb, auto);
    end
    vectors++;
    if ({dataout, dp, turn_off} !== {16'h0, 4'h0, 4'hF}) begin
      errors++; $display("FAIL reset_out: got data=%h dp=%b off=%b want 0000/0000/1111", dataout, dp, turn_off);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_capture();
    data_in[15:0] = 16'h0123;
    valid_in = 4'b0001;
    @(negedge clk);
    valid_in = '0;
    vectors++;
    if (dataout !== 16'h0) begin errors++; $display("FAIL capture_early: got %h want 0000", dataout); end
    @(negedge clk);
    vectors++;
    if (dataout !== 16'h0123) begin errors++; $display("FAIL capture_data: got %h want 0123", dataout); end
    vectors++;
    if (turn_off !== 4'b1000) begin errors++; $display("FAIL capture_blank: got %b want 1000", turn_off); end
  endtask

  task automatic test_dp_blank();
    int n;
    data_in[31:16] = 16'h0005;
    valid_in = 4'b0010;
    @(negedge clk);
    valid_in = '0;
    press(1, n);
    vectors++;
    if (n !== 1 || chan !== 2'd1) begin errors++; $display("FAIL adv1: got stb=%0d chan=%0d want 1/1", n, chan); end
    vectors++;
    if ({dataout, dp, turn_off} !== {16'h0005, 4'b0010, 4'b1100}) begin
      errors++; $display("FAIL dp_blank: got data=%h dp=%b off=%b want 0005/0010/1100", dataout, dp, turn_off);
    end
    press(1, n);
    vectors++;
    if (n !== 1 || chan !== 2'd2) begin errors++; $display("FAIL adv2: got stb=%0d chan=%0d want 1/2", n, chan); end
    vectors++;
    if (turn_off !== 4'hF) begin errors++; $display("FAIL unseen_blank: got %b want 1111", turn_off); end
  endtask

  task automatic test_wrap();
    int n, total;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      press(1, n);
      total += n;
      vectors++;
      if (chan !== 2'((3 + i) % 4)) begin errors++; $display("FAIL wrap_seq: got %0d want %0d", chan, (3 + i) % 4); end
    end
    vectors++;
    if (total !== 4) begin errors++; $display("FAIL wrap_stb: got %0d want 4", total); end
  endtask

  task automatic test_hold();
    logic [15:0] old;
    int cur;
    cur = int'(chan);
    old = dataout;
    hold = 1'b1;
    data_in[cur*DW +: DW] = 16'h0999;
    valid_in = 4'(1 << cur);
    @(negedge clk);
    valid_in = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (dataout !== old || turn_off !== 4'hF) begin
      errors++; $display("FAIL hold_freeze: got data=%h off=%b want %h/1111", dataout, turn_off, old);
    end
    hold = 1'b0;
    @(negedge clk);
    vectors++;
    if (dataout !== 16'h0999 || turn_off !== 4'b1000) begin
      errors++; $display("FAIL hold_release: got data=%h off=%b want 0999/1000", dataout, turn_off);
    end
  endtask

  task automatic test_btn_reset();
    int n;
    btn = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); n += int'(chan_stb); end
    btn = 1'b0;
    repeat (4) begin @(negedge clk); n += int'(chan_stb); end
    vectors++;
    if (n !== 0 || chan !== 2'd0 || auto !== 1'b0) begin
      errors++; $display("FAIL btn_thru_reset: got stb=%0d chan=%0d auto=%b want 0/0/0", n, chan, auto);
    end
    press(1, n);
    vectors++;
    if (n !== 1 || chan !== 2'd1) begin errors++; $display("FAIL post_reset_press: got stb=%0d chan=%0d want 1/1", n, chan); end
  endtask

  task automatic test_auto();
    int n, start;
    start = int'(chan);
`ifdef DISP_AUTOROTATE_EN
    begin
      int last, cnt;
      press(6, n);
      vectors++;
      if (n !== 0 || auto !== 1'b1 || chan !== 2'(start)) begin
        errors++; $display("FAIL long_on: got stb=%0d auto=%b chan=%0d want 0/1/%0d", n, auto, chan, start);
      end
      last = -1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (chan_stb) begin
          if (last >= 0) begin
            vectors++;
            if (i - last !== DWELL) begin errors++; $display("FAIL auto_period: got %0d want %0d", i - last, DWELL); end
          end
          last = i;
          cnt++;
        end
      end
      vectors++;
      if (cnt < 3 || chan !== 2'((start + cnt) % 4)) begin
        errors++; $display("FAIL auto_rotate: got pulses=%0d chan=%0d want >=3/%0d", cnt, chan, (start + cnt) % 4);
      end
      press(6, n);
      vectors++;
      if (auto !== 1'b0) begin errors++; $display("FAIL long_off: got %b want 0", auto); end
      n = 0;
      repeat (20) begin @(negedge clk); n += int'(chan_stb); end
      vectors++;
      if (n !== 0) begin errors++; $display("FAIL auto_stopped: got %0d pulses want 0", n); end
    end
`else
    press(6, n);
    vectors++;
    if (n !== 1 || auto !== 1'b0 || chan !== 2'((start + 1) % 4)) begin
      errors++; $display("FAIL long_plain: got stb=%0d auto=%b chan=%0d want 1/0/%0d", n, auto, chan, (start + 1) % 4);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      vectors++;
      if (dataout !== e_data) begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", i, dataout, e_data); end
      vectors++;
      if ({dp, turn_off} !== {e_dp, e_to}) begin
        errors++; $display("FAIL rnd_dp_off @%0d: got %b/%b want %b/%b", i, dp, turn_off, e_dp, e_to);
      end
      vectors++;
      if ({chan, chan_stb, auto} !== {2'(m_chan), e_stb, m_auto}) begin
        errors++; $display("FAIL rnd_chan @%0d: got %0d/%b/%b want %0d/%b/%b", i, chan, chan_stb, auto, m_chan, e_stb, m_auto);
      end
      if ($urandom_range(5) == 0) btn = ~btn;
      if ($urandom_range(15) == 0) hold = ~hold;
      for (int c = 0; c < NCH; c++) begin
        valid_in[c] = ($urandom_range(3) == 0);
        data_in[c*DW +: DW] = rand_bcd();
      end
    end
    btn = 1'b0;
    hold = 1'b0;
    valid_in = '0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_dp_blank();
    test_wrap();
    test_hold();
    test_btn_reset();
    test_auto();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
